// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register with a ready-handshake data port.
// Optional wait timeout with sticky error when MEMWB_TIMEOUT_EN is defined.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        MemErrW
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          reg_write_q, reg_write_d;
  logic [1:0]    result_src_q, result_src_d;
  logic [31:0]   alu_result_q, alu_result_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   pc_plus4_q, pc_plus4_d;

  logic access;
  logic abort;
  logic complete;

  always_comb begin
    access = MemWriteM | (ResultSrcM == 2'b01);
`ifdef MEMWB_TIMEOUT_EN
    abort = (state_q == S_WAIT) && (wait_cnt_q == CW'(TIMEOUT_CYCLES)) && !dmem_ready;
`else
    abort = 1'b0;
`endif
    complete   = access & dmem_ready;
    dmem_req   = access & ~abort;
    dmem_we    = MemWriteM;
    dmem_addr  = ALUResultM;
    dmem_wdata = WriteDataM;
    StallM     = access & ~dmem_ready & ~abort;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (access && !dmem_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready || abort) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Non-memory ops and completed accesses advance; stall and abort cycles insert a bubble.
  always_comb begin
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    rd_d         = rd_q;
    pc_plus4_d   = pc_plus4_q;
    if (!access || complete) begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      alu_result_d = ALUResultM;
      rd_d         = RdM;
      pc_plus4_d   = PCPlus4M;
      if (complete && !MemWriteM) begin
        read_data_d = dmem_rdata;
      end
    end else begin
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

`ifdef MEMWB_TIMEOUT_EN
  logic mem_err_q, mem_err_d;

  always_comb begin
    mem_err_d = mem_err_q | abort;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= mem_err_d;
    end
  end

  assign MemErrW = mem_err_q;
`else
  assign MemErrW = 1'b0;
`endif

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pc_plus4_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        MemErrW;

  int unsigned n_vec;
  int unsigned n_bad;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCPlus4M   (PCPlus4M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RdW        (RdW),
    .PCPlus4W   (PCPlus4W),
    .MemErrW    (MemErrW)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    ALUResultM = alu;
    WriteDataM = wd;
    RdM        = rd;
    PCPlus4M   = pc4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_m(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  int unsigned stall_ok;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    set_m(1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #3;
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_alu",      ALUResultW, 32'd0);
    chk("rst_rdata",    ReadDataW, 32'd0);
    chk("rst_memerr",   32'(MemErrW), 32'd0);
    chk("rst_stall",    32'(StallM), 32'd0);
    step();
    reset = 1'b1;

    // ALU op; ready high with no request must be ignored
    set_m(1'b1, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h44);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1111_1111;
    #1;
    chk("alu_stall", 32'(StallM), 32'd0);
    chk("alu_req",   32'(dmem_req), 32'd0);
    step();
    chk("alu_rw",    32'(RegWriteW), 32'd1);
    chk("alu_rd",    32'(RdW), 32'd5);
    chk("alu_res",   ALUResultW, 32'h1234);
    chk("alu_pc4",   PCPlus4W, 32'h44);
    chk("alu_rdata", ReadDataW, 32'd0);

    // Zero-wait load
    set_m(1'b1, 2'b01, 1'b0, 32'h100, 32'h0, 5'd7, 32'h48);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld0_req",   32'(dmem_req), 32'd1);
    chk("ld0_we",    32'(dmem_we), 32'd0);
    chk("ld0_addr",  dmem_addr, 32'h100);
    chk("ld0_stall", 32'(StallM), 32'd0);
    step();
    chk("ld0_rdata", ReadDataW, 32'hDEAD_BEEF);
    chk("ld0_src",   32'(ResultSrcW), 32'd1);
    chk("ld0_rd",    32'(RdW), 32'd7);

    // Store with three wait cycles
    set_m(1'b0, 2'b00, 1'b1, 32'h200, 32'hCAFE_F00D, 5'd0, 32'h208);
    dmem_ready = 1'b0;
    dmem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", 32'(StallM), 32'd1);
      chk("st_we",    32'(dmem_we), 32'd1);
      chk("st_addr",  dmem_addr, 32'h200);
      chk("st_wdata", dmem_wdata, 32'hCAFE_F00D);
      step();
      chk("st_bub_rw",  32'(RegWriteW), 32'd0);
      chk("st_bub_src", 32'(ResultSrcW), 32'd0);
      chk("st_bub_alu", ALUResultW, 32'h100);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h5555_5555;
    #1;
    chk("st_done_stall", 32'(StallM), 32'd0);
    step();
    chk("st_w_alu",   ALUResultW, 32'h200);
    chk("st_w_pc4",   PCPlus4W, 32'h208);
    chk("st_w_rw",    32'(RegWriteW), 32'd0);
    chk("st_w_rdata", ReadDataW, 32'hDEAD_BEEF);

    // Back-to-back load, no idle gap
    set_m(1'b1, 2'b01, 1'b0, 32'h300, 32'h0, 5'd9, 32'h20C);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    #1;
    chk("b2b_req", 32'(dmem_req), 32'd1);
    step();
    chk("b2b_rdata", ReadDataW, 32'h1357_9BDF);
    chk("b2b_rd",    32'(RdW), 32'd9);

    // Store and load select together act as a write
    set_m(1'b0, 2'b01, 1'b1, 32'h400, 32'h77, 5'd3, 32'h210);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("both_we", 32'(dmem_we), 32'd1);
    step();
    chk("both_rdata", ReadDataW, 32'h1357_9BDF);
    chk("both_alu",   ALUResultW, 32'h400);

    // Load with one wait cycle
    set_m(1'b1, 2'b01, 1'b0, 32'h500, 32'h0, 5'd11, 32'h214);
    dmem_ready = 1'b0;
    #1;
    chk("ld1_stall", 32'(StallM), 32'd1);
    step();
    chk("ld1_bub_rw", 32'(RegWriteW), 32'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h2468_ACE0;
    #1;
    chk("ld1_done_stall", 32'(StallM), 32'd0);
    step();
    chk("ld1_rdata", ReadDataW, 32'h2468_ACE0);
    chk("ld1_rw",    32'(RegWriteW), 32'd1);
    chk("ld1_rd",    32'(RdW), 32'd11);

    // Reset asserted mid-WAIT clears W immediately
    set_m(1'b1, 2'b01, 1'b0, 32'h600, 32'h0, 5'd12, 32'h218);
    dmem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rstw_rw",    32'(RegWriteW), 32'd0);
    chk("rstw_alu",   ALUResultW, 32'd0);
    chk("rstw_rdata", ReadDataW, 32'd0);
    chk("rstw_rd",    32'(RdW), 32'd0);
    chk("rstw_pc4",   PCPlus4W, 32'd0);
    chk("rstw_err",   32'(MemErrW), 32'd0);
    do_reset();
    set_m(1'b1, 2'b01, 1'b0, 32'h700, 32'h0, 5'd13, 32'h21C);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hA5A5_5A5A;
    step();
    chk("post_rst_rdata", ReadDataW, 32'hA5A5_5A5A);

`ifdef MEMWB_TIMEOUT_EN
    // Ready on the would-be abort cycle wins
    do_reset();
    set_m(1'b1, 2'b01, 1'b0, 32'h800, 32'h0, 5'd14, 32'h220);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tow_stall", 32'(StallM), 32'd1);
      step();
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0F0F_0F0F;
    #1;
    chk("tow_req", 32'(dmem_req), 32'd1);
    step();
    chk("tow_rdata", ReadDataW, 32'h0F0F_0F0F);
    chk("tow_err",   32'(MemErrW), 32'd0);

    // Load never ready: four stalls then abort
    set_m(1'b1, 2'b01, 1'b0, 32'h900, 32'h0, 5'd15, 32'h224);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", 32'(StallM), 32'd1);
      step();
    end
    #1;
    chk("to_abort_stall", 32'(StallM), 32'd0);
    chk("to_abort_req",   32'(dmem_req), 32'd0);
    step();
    chk("to_err",    32'(MemErrW), 32'd1);
    chk("to_bub_rw", 32'(RegWriteW), 32'd0);
    chk("to_alu",    ALUResultW, 32'h800);
    set_m(1'b1, 2'b00, 1'b0, 32'hA00, 32'h0, 5'd1, 32'h228);
    step();
    set_m(1'b1, 2'b01, 1'b0, 32'hB00, 32'h0, 5'd2, 32'h22C);
    dmem_ready = 1'b1;
    step();
    chk("to_err_sticky", 32'(MemErrW), 32'd1);
    chk("to_after_alu",  ALUResultW, 32'hB00);
`else
    // Load never ready: stall indefinitely, no error
    do_reset();
    set_m(1'b1, 2'b01, 1'b0, 32'h900, 32'h0, 5'd15, 32'h224);
    dmem_ready = 1'b0;
    stall_ok = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (StallM === 1'b1 && MemErrW === 1'b0 && dmem_req === 1'b1) stall_ok++;
      step();
    end
    chk("nto_stall_cycles", stall_ok, 32'd100);
    chk("nto_err",          32'(MemErrW), 32'd0);
    chk("nto_bub_rw",       32'(RegWriteW), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
